execute_stage: RTL and testbench

- Y86-64 pipeline execute stage, directly downstream of the register file and the SRC/DEST selection logic.
- Latches decode-stage outputs into an E pipeline register.
- Computes the ALU result, maintains the condition-code register and resolves Cnd.
- Delivers results into an M pipeline register for memory/write-back. Also exposes combinational e_valE/e_dstE for forwarding back to decode.

---
 rtl/execute_stage.sv | 162 ++++++++++++++++
 tb/tb_execute_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes, Cnd
// resolution and the M pipeline register, plus e_valE/e_dstE for forwarding.
module execute_stage #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          d_icode,
    input  logic [3:0]          d_ifun,
    input  logic [DATA_WID-1:0] d_valC,
    input  logic [DATA_WID-1:0] d_valA,
    input  logic [DATA_WID-1:0] d_valB,
    input  logic [ADDR_WID-1:0] d_dstE,
    input  logic [ADDR_WID-1:0] d_dstM,
    input  logic                E_stall,
    input  logic                E_bubble,
    input  logic                M_bubble,
    input  logic                cc_inhibit,
    output logic [DATA_WID-1:0] e_valE,
    output logic [ADDR_WID-1:0] e_dstE,
    output logic [3:0]          M_icode,
    output logic                M_Cnd,
    output logic [DATA_WID-1:0] M_valE,
    output logic [DATA_WID-1:0] M_valA,
    output logic [ADDR_WID-1:0] M_dstE,
    output logic [ADDR_WID-1:0] M_dstM,
    output logic [2:0]          cc_out
);
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [DATA_WID-1:0] EIGHT     = DATA_WID'(8);
    localparam logic [DATA_WID-1:0] NEG_EIGHT = '0 - EIGHT;
    localparam logic [ADDR_WID-1:0] NONREG    = '1;

    logic [3:0]          ex_icode, ex_ifun;
    logic [DATA_WID-1:0] ex_valc, ex_vala, ex_valb;
    logic [ADDR_WID-1:0] ex_dste, ex_dstm;
    logic [2:0]          cc_q;

    logic [DATA_WID-1:0] alua, alub, result;
    logic [3:0]          aluop;
    logic                zf, sf, of, cnd;

    always_ff @(posedge CLK) begin
        if (RST || E_bubble) begin
            ex_icode <= I_NOP;
            ex_ifun  <= 4'h0;
            ex_valc  <= '0;
            ex_vala  <= '0;
            ex_valb  <= '0;
            ex_dste  <= NONREG;
            ex_dstm  <= NONREG;
        end else if (!E_stall) begin
            ex_icode <= d_icode;
            ex_ifun  <= d_ifun;
            ex_valc  <= d_valC;
            ex_vala  <= d_valA;
            ex_valb  <= d_valB;
            ex_dste  <= d_dstE;
            ex_dstm  <= d_dstM;
        end
    end

    always_comb begin
        alua = '0;
        alub = '0;
        case (ex_icode)
            I_RRMOV, I_OPQ:          alua = ex_vala;
            I_IRMOV, I_RMMOV, I_MRMOV: alua = ex_valc;
            I_CALL, I_PUSH:          alua = NEG_EIGHT;
            I_RET, I_POP:            alua = EIGHT;
            default:                 alua = '0;
        endcase
        case (ex_icode)
            I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_PUSH, I_RET, I_POP: alub = ex_valb;
            default:                                               alub = '0;
        endcase
    end

    // Address arithmetic and moves always add; only OPq selects the operation.
    always_comb begin
        aluop  = (ex_icode == I_OPQ) ? ex_ifun : ALU_ADD;
        result = alub + alua;
        of     = 1'b0;
        case (aluop)
            ALU_SUB: begin
                result = alub - alua;
                of     = (alub[DATA_WID-1] != alua[DATA_WID-1]) &&
                         (result[DATA_WID-1] != alub[DATA_WID-1]);
            end
            ALU_AND: result = alub & alua;
            ALU_XOR: result = alub ^ alua;
            default: begin
                result = alub + alua;
                of     = (alua[DATA_WID-1] == alub[DATA_WID-1]) &&
                         (result[DATA_WID-1] != alua[DATA_WID-1]);
            end
        endcase
        zf = (result == '0);
        sf = result[DATA_WID-1];
    end

    // Cnd reads the flags as they stood before this instruction's own update.
    always_comb begin
        cnd = 1'b0;
        case (ex_ifun)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2: cnd = cc_q[1] ^ cc_q[0];
            4'h3: cnd = cc_q[2];
            4'h4: cnd = ~cc_q[2];
            4'h5: cnd = ~(cc_q[1] ^ cc_q[0]);
            4'h6: cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cnd = 1'b0;
        endcase
    end

    assign e_valE = result;
    assign e_dstE = ((ex_icode == I_RRMOV) && !cnd) ? NONREG : ex_dste;
    assign cc_out = cc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cc_q <= 3'b100;
        end else if ((ex_icode == I_OPQ) && !cc_inhibit) begin
            cc_q <= {zf, sf, of};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || M_bubble) begin
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= NONREG;
            M_dstM  <= NONREG;
        end else begin
            M_icode <= ex_icode;
            M_Cnd   <= cnd;
            M_valE  <= result;
            M_valA  <= ex_vala;
            M_dstE  <= e_dstE;
            M_dstM  <= ex_dstm;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios then random instruction streams,
// each cycle checked against an instruction-level reference model.
module tb_execute_stage;
    logic        CLK, RST;
    logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
    logic [63:0] d_valC, d_valA, d_valB;
    logic        E_stall, E_bubble, M_bubble, cc_inhibit;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
    logic        M_Cnd;
    logic [2:0]  cc_out;

    int vectors = 0;
    int miscompares = 0;

    execute_stage #(.DATA_WID(64), .ADDR_WID(4)) dut (
        .CLK(CLK), .RST(RST),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA),
        .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .E_stall(E_stall), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .cc_inhibit(cc_inhibit),
        .e_valE(e_valE), .e_dstE(e_dstE),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_out(cc_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state: the instruction sitting in E, the M outputs, CC.
    logic [3:0]  xi, xf, xde, xdm;
    logic [63:0] xc, xa, xb;
    logic [3:0]  mi, mde, mdm;
    logic        mcnd;
    logic [63:0] mve, mva;
    logic [2:0]  mcc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operation semantics straight from the instruction set; overflow found by
    // doing the arithmetic one bit wider and seeing whether it fits.
    function automatic logic [63:0] ref_alu(input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [63:0] c, input logic [63:0] a,
                                            input logic [63:0] b, output logic [2:0] fl);
        logic [63:0] opa, opb, r;
        logic [64:0] w;
        logic        ovf;
        opa = 64'd0;
        opb = 64'd0;
        if (ic == 4'h2 || ic == 4'h6) opa = a;
        else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) opa = c;
        else if (ic == 4'h8 || ic == 4'hA) opa = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic == 4'h9 || ic == 4'hB) opa = 64'd8;
        if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) opb = b;
        ovf = 1'b0;
        if (ic == 4'h6 && fn == 4'h1) begin
            w = {opb[63], opb} - {opa[63], opa};
            r = w[63:0];
            ovf = (w[64] != w[63]);
        end else if (ic == 4'h6 && fn == 4'h2) begin
            r = opb & opa;
        end else if (ic == 4'h6 && fn == 4'h3) begin
            r = opb ^ opa;
        end else begin
            w = {opb[63], opb} + {opa[63], opa};
            r = w[63:0];
            ovf = (w[64] != w[63]);
        end
        fl = {(r == 64'd0), r[63], ovf};
        return r;
    endfunction

    function automatic logic ref_cnd(input logic [2:0] cc, input logic [3:0] fn);
        logic z, s, o;
        {z, s, o} = cc;
        case (fn)
            4'h0: return 1'b1;
            4'h1: return (s != o) || z;
            4'h2: return s != o;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return s == o;
            4'h6: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        xi = 4'h1; xf = 4'h0; xc = 0; xa = 0; xb = 0; xde = 4'hF; xdm = 4'hF;
        mi = 4'h1; mcnd = 1'b0; mve = 0; mva = 0; mde = 4'hF; mdm = 4'hF;
        mcc = 3'b100;
    endtask

    task automatic step(input logic rst, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic st, input logic eb, input logic mb, input logic inh);
        logic [63:0] res;
        logic [2:0]  fl;
        logic        cn;
        logic [3:0]  dee;
        RST = rst; d_icode = ic; d_ifun = fn; d_valC = c; d_valA = a; d_valB = b;
        d_dstE = de; d_dstM = dm; E_stall = st; E_bubble = eb; M_bubble = mb;
        cc_inhibit = inh;
        @(negedge CLK);
        res = ref_alu(xi, xf, xc, xa, xb, fl);
        cn  = ref_cnd(mcc, xf);
        dee = (xi == 4'h2 && !cn) ? 4'hF : xde;
        chk("e_valE", e_valE, res);
        chk("e_dstE", {60'd0, e_dstE}, {60'd0, dee});
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else begin
            if (xi == 4'h6 && !inh) mcc = fl;
            if (mb) begin
                mi = 4'h1; mcnd = 1'b0; mve = 0; mva = 0; mde = 4'hF; mdm = 4'hF;
            end else begin
                mi = xi; mcnd = cn; mve = res; mva = xa; mde = dee; mdm = xdm;
            end
            if (eb) begin
                xi = 4'h1; xf = 4'h0; xc = 0; xa = 0; xb = 0; xde = 4'hF; xdm = 4'hF;
            end else if (!st) begin
                xi = ic; xf = fn; xc = c; xa = a; xb = b; xde = de; xdm = dm;
            end
        end
        #1;
        chk("M_icode", {60'd0, M_icode}, {60'd0, mi});
        chk("M_Cnd",   {63'd0, M_Cnd},   {63'd0, mcnd});
        chk("M_valE",  M_valE, mve);
        chk("M_valA",  M_valA, mva);
        chk("M_dstE",  {60'd0, M_dstE},  {60'd0, mde});
        chk("M_dstM",  {60'd0, M_dstM},  {60'd0, mdm});
        chk("cc_out",  {61'd0, cc_out},  {61'd0, mcc});
    endtask

    task automatic nop();
        step(0, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
    endtask

    function automatic logic [63:0] rv();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        RST = 1'b1; d_icode = 4'h1; d_ifun = 0; d_valC = 0; d_valA = 0; d_valB = 0;
        d_dstE = 4'hF; d_dstM = 4'hF; E_stall = 0; E_bubble = 0; M_bubble = 0;
        cc_inhibit = 0;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset state
        step(1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
        chk("rst_icode", {60'd0, M_icode}, 64'd1);
        chk("rst_cc", {61'd0, cc_out}, 64'd4);

        // IRMOV valC=3 -> r0
        step(0, 4'h3, 4'h0, 64'd3, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0);
        nop();
        chk("irmov_valE", M_valE, 64'd3);
        chk("irmov_dstE", {60'd0, M_dstE}, 64'd0);

        // SUB 5-5, then ADD overflow
        step(0, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 0, 0, 0, 0);
        step(0, 4'h6, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, 4'hF, 0, 0, 0, 0);
        chk("sub_cc", {61'd0, cc_out}, 64'd4);
        nop();
        chk("add_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("add_cc", {61'd0, cc_out}, 64'd3);

        // Make CC = SF only, then cmovl (taken) and cmovge (not taken)
        step(0, 4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h4, 4'hF, 0, 0, 0, 0);
        step(0, 4'h2, 4'h2, 0, 64'd9, 0, 4'h1, 4'hF, 0, 0, 0, 0);
        chk("sf_cc", {61'd0, cc_out}, 64'd2);
        step(0, 4'h2, 4'h5, 0, 64'd9, 0, 4'h1, 4'hF, 0, 0, 0, 0);
        chk("cmovl_cnd", {63'd0, M_Cnd}, 64'd1);
        chk("cmovl_dstE", {60'd0, M_dstE}, 64'd1);
        nop();
        chk("cmovge_cnd", {63'd0, M_Cnd}, 64'd0);
        chk("cmovge_dstE", {60'd0, M_dstE}, 64'hF);

        // PUSH / POP stack arithmetic, then an inhibited CC update
        step(0, 4'hA, 4'h0, 0, 0, 64'h100, 4'h4, 4'hF, 0, 0, 0, 0);
        step(0, 4'hB, 4'h0, 0, 0, 64'hF8, 4'h4, 4'h5, 0, 0, 0, 0);
        chk("push_valE", M_valE, 64'hF8);
        step(0, 4'h6, 4'h0, 0, 64'd1, 64'd1, 4'h6, 4'hF, 0, 0, 0, 0);
        chk("pop_valE", M_valE, 64'h100);
        step(0, 4'h8, 4'h0, 0, 0, 64'h200, 4'h4, 4'hF, 0, 0, 0, 1);
        chk("inhibit_cc", {61'd0, cc_out}, 64'd2);
        nop();

        // Stall E with M bubbles around an ADD 2+3
        step(0, 4'h6, 4'h0, 0, 64'd2, 64'd3, 4'h7, 4'hF, 0, 0, 0, 0);
        step(0, 4'h3, 4'h0, 64'd77, 0, 0, 4'h1, 4'hF, 1, 0, 1, 0);
        chk("stall1_icode", {60'd0, M_icode}, 64'd1);
        step(0, 4'h3, 4'h0, 64'd77, 0, 0, 4'h1, 4'hF, 1, 0, 1, 0);
        chk("stall2_icode", {60'd0, M_icode}, 64'd1);
        nop();
        chk("stall_valE", M_valE, 64'd5);

        // Reset in mid-flight
        step(0, 4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h1, 4'h2, 0, 0, 0, 0);
        step(1, 4'h6, 4'h0, 0, 64'd4, 64'd4, 4'h1, 4'h2, 0, 0, 0, 0);
        chk("midrst_cc", {61'd0, cc_out}, 64'd4);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ic;
            ic = 4'($urandom_range(0, 11));
            step(($urandom_range(0, 49) == 0), ic,
                 (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7)),
                 rv(), rv(), rv(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
